uart_xcvr: RTL and testbench
============================

# uart_xcvr

Parametrised full-duplex UART transceiver that replaces the fixed 8N1 transmit/receive pair. It runs entirely on `clk`, with no derived clocks: a clock-enable prescaler produces the oversampling tick. It supports configurable data width, parity, stop bits and oversampling. The receiver re-aligns to every start bit and reports parity and framing errors. It sits between the host-side byte interface and the external serial pins.

## Interface
- `CLK_FREQ`, 1000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line bit rate.
- `OVERSAMPLE`, 16, ticks per bit; must be an even number ≥ 4.
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, number of stop bits (1 or 2).

Derived values:
- DIV = max(1, CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), integer floor.
- BIT_CLKS = DIV*OVERSAMPLE.
- FRAME = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Illegal parameter values cause an elaboration error.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tx_data` in DATA_BITS: word to send, sent LSB first.
- `tx_valid` in 1: transmit request.
- `tx_ready` out 1: transmitter idle, can accept a word.
- `tx` out 1: serial output; idle level is high.
- `rx` in 1: serial input; asynchronous to `clk`.
- `rx_data` out DATA_BITS: last received word.
- `rx_valid` out 1: one-cycle pulse when a frame completes.
- `rx_parity_err` out 1: parity mismatch for the frame; valid while `rx_valid` is high.
- `rx_frame_err` out 1: first stop bit sampled low; valid while `rx_valid` is high.

## Operation
- **Reset values:** `tx`=1, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, both error flags 0. Both FSMs go to IDLE and all counters clear.
- **Reset mid-frame:** the partial frame is abandoned. `tx` is 1 in the first cycle after `rst`. No `rx_valid` is produced for the abandoned frame.

TX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):
- A word is accepted when `tx_valid` && `tx_ready`. `tx_data` is latched at that edge.
- `tx_ready` is 1 only in IDLE.
- `tx_valid` while busy is ignored; requests are not queued.
- The TX bit timer restarts at acceptance. Each bit lasts exactly BIT_CLKS cycles.
- PARITY is skipped when `PARITY`=0.
- Parity bit value: XOR of the data bits for even parity; its complement for odd parity.
- STOP lasts STOP_BITS×BIT_CLKS cycles.

RX FSM (IDLE → START → DATA → PARITY → STOP → IDLE, plus WAIT_HIGH):
- `rx` passes through a 2-flop synchroniser. All behaviour below refers to the synchronised signal `rxs`.
- **Start detection:** in IDLE, `rxs`=0 starts the tick counter.
- **Start confirmation:** at OVERSAMPLE/2 ticks, `rxs` is re-sampled. If it is 1, the start is false: the FSM returns to IDLE with no output.
- **Bit sampling:** each subsequent bit is sampled once, every OVERSAMPLE ticks after the start midpoint, i.e. at the bit centre.
- Data bits shift in LSB first.
- `rx_parity_err` = (received parity ≠ computed parity). It is always 0 when `PARITY`=0.
- Only the first stop bit is sampled; with STOP_BITS=2, the receiver re-arms after the first stop bit.
- **End of frame:** on the cycle after the stop sample, `rx_valid` pulses for one cycle. `rx_data` updates at that same edge and holds until the next frame. The error flags update with it.
- Data is delivered even when an error flag is set.
- **Framing error:** if the stop sample is 0, `rx_frame_err`=1 and the FSM enters WAIT_HIGH. It leaves WAIT_HIGH for IDLE only after `rxs`=1, so a held-low line (break) produces exactly one frame.
- **Error-free frame:** return to IDLE directly from the stop sample. This allows a start bit beginning half a bit later.
- TX and RX are fully independent. Simultaneous activity on both has no interaction.

## Timing
- **TX:** acceptance at edge T.
  - `tx` changes to the start bit at edge T+1.
  - Bit k of the frame occupies cycles T+1+k·BIT_CLKS through T+(k+1)·BIT_CLKS.
  - `tx_ready` returns to 1 at edge T+1+FRAME·BIT_CLKS.
  - Back-to-back words are accepted with no idle bit between frames.
- **RX:** let E be the first cycle with `rxs`=0. E is 2 cycles after `rx` falls.
  - Sample n (n=0 is the start bit) is taken at E + DIV·(OVERSAMPLE/2 + n·OVERSAMPLE).
  - `rx_valid` is high at the cycle after the first stop-bit sample.
- **Tolerance:** the receiver must decode correctly with transmitter baud error up to ±3% at OVERSAMPLE=16.

## Test plan
All tests use CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16, so DIV=1 and BIT_CLKS=16.
- **8N1 transmit:** send 0xA5. `tx` must output 0,1,0,1,0,0,1,0,1,1, each for 16 cycles. `tx_ready`=1 at 161 cycles after acceptance.
- **8E1 loopback:** tie `tx` to `rx` and send 0x3C. Expect `rx_valid` once, with `rx_data`=0x3C, `rx_parity_err`=0, `rx_frame_err`=0. Then send 0x3D back-to-back and expect `rx_data`=0x3D.
- **8O1 parity error:** drive data 0x01 with parity bit 1 (the correct bit is 0). Expect `rx_data`=0x01 and `rx_parity_err`=1.
- **Framing and break:** drive 8N1 0x00 with the stop bit 0, then hold `rx` low for 500 cycles. Expect exactly one `rx_valid`, with `rx_frame_err`=1 and `rx_data`=0x00. After `rx` returns high, the next valid frame (0x55) decodes cleanly.
- **Glitch rejection:** pulse `rx` low for 4 cycles. Expect no `rx_valid`, and the receiver decodes a following frame of 0x81.
- **Reset mid-frame:** assert `rst` during data bit 3 of a TX frame and during an RX frame. Expect `tx`=1 and `tx_ready`=1 the next cycle, no `rx_valid`, and `rx_data`=0.

Source files
------------

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART transceiver on a single clock.
// The receiver oversamples through a clock-enable prescaler and re-aligns on every start bit.
module uart_xcvr #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int BAUD_OS   = (BAUD_RATE * OVERSAMPLE > 0) ? BAUD_RATE * OVERSAMPLE : 1;
  localparam int DIV_RAW   = CLK_FREQ / BAUD_OS;
  localparam int DIV       = (DIV_RAW > 1) ? DIV_RAW : 1;
  localparam int BIT_CLKS  = DIV * OVERSAMPLE;
  localparam int STOP_CLKS = STOP_BITS * BIT_CLKS;
  localparam int TX_CW     = $clog2(STOP_CLKS + 1);
  localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W    = $clog2(OVERSAMPLE);
  localparam int IDX_W     = $clog2(DATA_BITS);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_xcvr: OVERSAMPLE must be an even number >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_xcvr: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_xcvr: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end
  if (CLK_FREQ <= 0 || BAUD_RATE <= 0) begin : g_bad_rates
    $error("uart_xcvr: CLK_FREQ and BAUD_RATE must be positive");
  end

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 2) ? ^w : ~^w;
  endfunction

  // ---------------------------------------------------------------- transmit
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [TX_CW-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_bit;
  logic                 tx_bit_end;

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      TX_START:  tx_bit = 1'b0;
      TX_DATA:   tx_bit = tx_shift[0];
      TX_PARITY: tx_bit = tx_par;
      default:   tx_bit = 1'b1;
    endcase
  end

  // STOP runs one cycle past its nominal length so tx_ready rises one cycle after the line
  // has finished the last stop bit, matching the registered start-bit delay at acceptance.
  always_comb begin
    if (tx_state == TX_STOP)
      tx_bit_end = (tx_cnt == TX_CW'(STOP_CLKS));
    else
      tx_bit_end = (tx_cnt == TX_CW'(BIT_CLKS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      if (tx_state != TX_IDLE && tx_cnt == '0)
        tx <= tx_bit;
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_par   <= parity_of(tx_data);
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end
        end
        default: begin
          if (!tx_bit_end) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: tx_state <= TX_DATA;
              TX_DATA: begin
                tx_shift <= tx_shift >> 1;
                if (tx_idx == IDX_W'(DATA_BITS - 1))
                  tx_state <= (PARITY != 0) ? TX_PARITY : TX_STOP;
                else
                  tx_idx <= tx_idx + 1'b1;
              end
              TX_PARITY: tx_state <= TX_STOP;
              default: begin
                tx_state <= TX_IDLE;
                tx_ready <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t            rx_state;
  logic                 rx_meta;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 tick;
  logic                 sample_pt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    tick = (div_cnt == DIV_W'(DIV - 1));
    if (rx_state == RX_START)
      sample_pt = tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
    else
      sample_pt = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      div_cnt       <= '0;
      tick_cnt      <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            rx_state <= RX_START;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs)
            rx_state <= RX_IDLE;
        end
        default: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick)
            tick_cnt <= sample_pt ? '0 : tick_cnt + 1'b1;
          if (sample_pt) begin
            case (rx_state)
              RX_START: begin
                rx_idx   <= '0;
                rx_state <= rxs ? RX_IDLE : RX_DATA;
              end
              RX_DATA: begin
                rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                if (rx_idx == IDX_W'(DATA_BITS - 1))
                  rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                else
                  rx_idx <= rx_idx + 1'b1;
              end
              RX_PARITY: begin
                rx_par_bit <= rxs;
                rx_state   <= RX_STOP;
              end
              RX_STOP: begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_shift;
                rx_parity_err <= (PARITY != 0) && (rx_par_bit != parity_of(rx_shift));
                rx_frame_err  <= !rxs;
                rx_state      <= rxs ? RX_IDLE : RX_WAIT_HIGH;
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: three transceivers (no, odd, even parity; 8 data bits, 1 stop) checked
// against a frame model built from the character-format rules.
`timescale 1ns/1ps
module tb_uart_xcvr;
  localparam int NI = 3;
  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data  [NI];
  logic       tx_valid [NI];
  logic       tx_ready [NI];
  logic       tx_line  [NI];
  logic       rx_line  [NI];
  logic       rx_drv   [NI];
  logic       loop_en  [NI];
  logic [7:0] rx_data  [NI];
  logic       rx_valid [NI];
  logic       rx_perr  [NI];
  logic       rx_ferr  [NI];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } cap_t;
  cap_t caps[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign rx_line[g] = loop_en[g] ? tx_line[g] : rx_drv[g];
    uart_xcvr #(
      .CLK_FREQ  (1600000),
      .BAUD_RATE (100000),
      .OVERSAMPLE(16),
      .DATA_BITS (8),
      .PARITY    (g),
      .STOP_BITS (1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (tx_data[g]),
      .tx_valid     (tx_valid[g]),
      .tx_ready     (tx_ready[g]),
      .tx           (tx_line[g]),
      .rx           (rx_line[g]),
      .rx_data      (rx_data[g]),
      .rx_valid     (rx_valid[g]),
      .rx_parity_err(rx_perr[g]),
      .rx_frame_err (rx_ferr[g])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      if (rx_valid[i] === 1'b1)
        caps.push_back('{i, rx_data[i], rx_perr[i], rx_ferr[i]});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame bit k at index k: start, data LSB first, optional parity, stop (mode = parity setting).
  function automatic logic [15:0] frame_of(input logic [7:0] w, input int mode);
    logic [15:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    ones = $countones(w);
    if (mode == 2) f[9] = ((ones % 2) == 1);
    else if (mode == 1) f[9] = ((ones % 2) == 0);
    return f;
  endfunction

  function automatic int frame_len(input int mode);
    return (mode != 0) ? 11 : 10;
  endfunction

  task automatic wait_ready(input int inst);
    int t;
    t = 0;
    @(negedge clk);
    while (tx_ready[inst] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("tx_ready_wait_i%0d", inst), tx_ready[inst], 1);
  endtask

  task automatic send_word(input int inst, input logic [7:0] w);
    wait_ready(inst);
    tx_data[inst]  = w;
    tx_valid[inst] = 1'b1;
    @(negedge clk);
    tx_valid[inst] = 1'b0;
  endtask

  task automatic tx_frame_check(input int inst, input logic [7:0] w);
    logic [15:0] f;
    int n, k, ph;
    f = frame_of(w, inst);
    n = frame_len(inst);
    send_word(inst, w);
    check($sformatf("tx_pre_start_i%0d", inst), tx_line[inst], 1);
    check($sformatf("tx_busy_i%0d", inst), tx_ready[inst], 0);
    for (int c = 1; c <= n * BC; c++) begin
      @(negedge clk);
      k  = (c - 1) / BC;
      ph = (c - 1) % BC;
      if (ph == 0 || ph == BC - 1)
        check($sformatf("tx_bit%0d_ph%0d_i%0d_w%02h", k, ph, inst, w), tx_line[inst], f[k]);
    end
    check($sformatf("tx_ready_late_i%0d", inst), tx_ready[inst], 0);
    @(negedge clk);
    check($sformatf("tx_ready_back_i%0d", inst), tx_ready[inst], 1);
    check($sformatf("tx_idle_i%0d", inst), tx_line[inst], 1);
  endtask

  // Drives n frame bits; l100 is the bit length in hundredths of a clock cycle.
  task automatic drive_bits(input int inst, input logic [15:0] f, input int n, input int l100);
    int cyc;
    for (int k = 0; k < n; k++) begin
      cyc = ((k + 1) * l100) / 100 - (k * l100) / 100;
      rx_drv[inst] = f[k];
      repeat (cyc) @(negedge clk);
    end
  endtask

  task automatic wait_caps(input int n, input int limit);
    int t;
    t = 0;
    while (caps.size() < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic check_cap(input string tag, input int idx, input int inst,
                           input logic [7:0] d, input logic pe, input logic fe);
    if (idx < caps.size()) begin
      check({tag, "_inst"}, caps[idx].inst, inst);
      check({tag, "_data"}, caps[idx].d, d);
      check({tag, "_perr"}, caps[idx].pe, pe);
      check({tag, "_ferr"}, caps[idx].fe, fe);
    end else begin
      check({tag, "_present"}, caps.size(), idx + 1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] f;
    logic [7:0]  w;
    int inst, n, l100;
    logic bad_par, bad_stop;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      tx_data[i]  = '0;
      tx_valid[i] = 1'b0;
      rx_drv[i]   = 1'b1;
      loop_en[i]  = 1'b0;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tx_i%0d", i), tx_line[i], 1);
      check($sformatf("rst_ready_i%0d", i), tx_ready[i], 1);
      check($sformatf("rst_rx_data_i%0d", i), rx_data[i], 0);
      check($sformatf("rst_rx_valid_i%0d", i), rx_valid[i], 0);
      check($sformatf("rst_perr_i%0d", i), rx_perr[i], 0);
      check($sformatf("rst_ferr_i%0d", i), rx_ferr[i], 0);
    end

    tx_frame_check(0, 8'hA5);
    for (int it = 0; it < 6; it++)
      tx_frame_check($urandom_range(0, 2), 8'($urandom));

    // 8E1 loopback with a back-to-back second word
    loop_en[2] = 1'b1;
    caps.delete();
    wait_ready(2);
    tx_data[2]  = 8'h3C;
    tx_valid[2] = 1'b1;
    @(negedge clk);
    tx_data[2] = 8'h3D;
    wait_ready(2);
    @(negedge clk);
    tx_valid[2] = 1'b0;
    wait_caps(2, 600);
    check("loop_e_count", caps.size(), 2);
    check_cap("loop_e_3c", 0, 2, 8'h3C, 1'b0, 1'b0);
    check_cap("loop_e_3d", 1, 2, 8'h3D, 1'b0, 1'b0);
    loop_en[2] = 1'b0;

    for (int it = 0; it < 6; it++) begin
      inst = $urandom_range(0, 2);
      w    = 8'($urandom);
      loop_en[inst] = 1'b1;
      caps.delete();
      send_word(inst, w);
      wait_caps(1, 400);
      check($sformatf("loop_count_i%0d", inst), caps.size(), 1);
      check_cap($sformatf("loop_i%0d_w%02h", inst, w), 0, inst, w, 1'b0, 1'b0);
      loop_en[inst] = 1'b0;
    end

    // 8O1 frame carrying a wrong parity bit
    caps.delete();
    f = frame_of(8'h01, 1);
    f[9] = 1'b1;
    drive_bits(1, f, 11, 1600);
    rx_drv[1] = 1'b1;
    wait_caps(1, 200);
    check("odd_perr_count", caps.size(), 1);
    check_cap("odd_perr", 0, 1, 8'h01, 1'b1, 1'b0);

    // framing error followed by a long break, then a clean frame
    caps.delete();
    drive_bits(0, 16'h0000, 10, 1600);
    repeat (500) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("break_count", caps.size(), 1);
    check_cap("break", 0, 0, 8'h00, 1'b0, 1'b1);
    caps.delete();
    drive_bits(0, frame_of(8'h55, 0), 10, 1600);
    rx_drv[0] = 1'b1;
    wait_caps(1, 200);
    check("after_break_count", caps.size(), 1);
    check_cap("after_break", 0, 0, 8'h55, 1'b0, 1'b0);

    // short low glitch must not start a frame
    caps.delete();
    rx_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", caps.size(), 0);
    drive_bits(0, frame_of(8'h81, 0), 10, 1600);
    rx_drv[0] = 1'b1;
    wait_caps(1, 200);
    check("post_glitch_count", caps.size(), 1);
    check_cap("post_glitch", 0, 0, 8'h81, 1'b0, 1'b0);

    // randomized receive frames with baud error and injected errors
    for (int it = 0; it < 12; it++) begin
      inst     = $urandom_range(0, 2);
      w        = 8'($urandom);
      bad_par  = (inst != 0) && ($urandom_range(0, 2) == 0);
      bad_stop = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       l100 = 1552;
        1:       l100 = 1600;
        default: l100 = 1648;
      endcase
      n = frame_len(inst);
      f = frame_of(w, inst);
      if (bad_par)  f[9]    = ~f[9];
      if (bad_stop) f[n-1]  = 1'b0;
      caps.delete();
      drive_bits(inst, f, n, l100);
      rx_drv[inst] = 1'b1;
      wait_caps(1, 200);
      check($sformatf("rxr_count_i%0d_w%02h", inst, w), caps.size(), 1);
      check_cap($sformatf("rxr_i%0d_w%02h_l%0d", inst, w, l100), 0, inst, w, bad_par, bad_stop);
    end

    // reset during TX data bit 3 and mid RX frame
    caps.delete();
    f = frame_of(8'($urandom), 0);
    send_word(0, 8'($urandom));
    for (int c = 0; c < 72; c++) begin
      rx_drv[0] = f[c / BC];
      @(negedge clk);
    end
    check("pre_rst_busy", tx_ready[0], 0);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    rx_drv[0] = 1'b1;
    check("mid_rst_tx", tx_line[0], 1);
    check("mid_rst_ready", tx_ready[0], 1);
    check("mid_rst_rx_data", rx_data[0], 0);
    check("mid_rst_perr", rx_perr[0], 0);
    check("mid_rst_ferr", rx_ferr[0], 0);
    repeat (300) @(negedge clk);
    check("mid_rst_no_valid", caps.size(), 0);
    check("mid_rst_tx_idle", tx_line[0], 1);
    check("mid_rst_rx_data_hold", rx_data[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
